// File: rtl/div8_seq.sv
// Iterative 8-bit unsigned restoring divider: one subtract-and-shift step per clock,
// with quotient/remainder/div_by_zero registered at completion and a one-cycle done.

module div8_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// 9-bit trial subtract t = a - {1'b0,b}, done as a + ~b + 1 on a ripple chain.
module div8_sub9 (
  input  logic [8:0] a,
  input  logic [7:0] b,
  output logic [8:0] t
);
  logic [8:0] c;
  assign c[0] = 1'b1;

  for (genvar gi = 0; gi < 8; gi++) begin : g_bit
    div8_fa u_fa (
      .a  (a[gi]),
      .b  (~b[gi]),
      .ci (c[gi]),
      .s  (t[gi]),
      .co (c[gi+1])
    );
  end

  // Top bit: inverted zero-extension bit is 1, so s = ~(a ^ c).
  assign t[8] = ~(a[8] ^ c[8]);
endmodule

module div8_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state;
  logic [7:0] q_sr;
  logic [7:0] d_reg;
  logic [7:0] r_reg;
  logic [2:0] count;

  logic [8:0] t;
  logic       no_borrow;
  logic [7:0] r_nxt;
  logic [7:0] q_nxt;

  div8_sub9 u_sub (
    .a ({r_reg, q_sr[7]}),
    .b (d_reg),
    .t (t)
  );

  // R < D holds every step, so t[8] is a clean borrow indicator.
  assign no_borrow = ~t[8];
  assign r_nxt     = no_borrow ? t[7:0] : {r_reg[6:0], q_sr[7]};
  assign q_nxt     = {q_sr[6:0], no_borrow};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      q_sr        <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            q_sr  <= dividend;
            d_reg <= divisor;
            r_reg <= '0;
            count <= '0;
            if (divisor == 8'd0) begin
              quotient    <= 8'hFF;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              busy        <= 1'b0;
              state       <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          q_sr  <= q_nxt;
          r_reg <= r_nxt;
          count <= count + 3'd1;
          if (count == 3'd7) begin
            quotient    <= q_nxt;
            remainder   <= r_nxt;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div8_seq.sv
// Randomized + directed bench for div8_seq against an arithmetic reference model.

module tb_div8_seq;
  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int n_chk = 0;
  int n_err = 0;

  div8_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive start for one sampling edge; returns #1 after that edge.
  task automatic start_op(input logic [7:0] n, input logic [7:0] d);
    @(negedge clk);
    start    = 1'b1;
    dividend = n;
    divisor  = d;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen; busy must be high on every waiting cycle.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 20) begin
      chk("busy_run", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
    end
  endtask

  task automatic check_result(input logic [7:0] n, input logic [7:0] d, input int cyc);
    int eq, er, ez, el;
    eq = (d == 0) ? 255 : n / d;
    er = (d == 0) ? n : n % d;
    ez = (d == 0) ? 1 : 0;
    el = (d == 0) ? 0 : 8;
    chk("latency", cyc, el);
    chk("done", {31'd0, done}, 32'd1);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    chk("quotient", {24'd0, quotient}, eq);
    chk("remainder", {24'd0, remainder}, er);
    chk("div_by_zero", {31'd0, div_by_zero}, ez);
    if (d != 0) begin
      chk("identity", quotient * d + remainder, {24'd0, n});
      chk("rem_lt_div", {31'd0, remainder < d}, 32'd1);
    end
  endtask

  task automatic do_op(input logic [7:0] n, input logic [7:0] d);
    int c;
    start_op(n, d);
    wait_done(c);
    check_result(n, d, c);
  endtask

  task automatic idle_gap();
    @(posedge clk);
    #1;
    chk("done_width", {31'd0, done}, 32'd0);
  endtask

  logic [7:0] tbl_n [7] = '{200, 255, 5, 0, 255, 128, 77};
  logic [7:0] tbl_d [7] = '{7, 1, 9, 3, 255, 2, 0};

  initial begin
    int c;
    logic [7:0] rn, rd;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    chk("rst_q", {24'd0, quotient}, 0);
    chk("rst_r", {24'd0, remainder}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_dbz", {31'd0, div_by_zero}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed corners, including divide by zero.
    for (int i = 0; i < 7; i++) begin
      do_op(tbl_n[i], tbl_d[i]);
      idle_gap();
    end

    // start mid-RUN is ignored, then back-to-back start in the DONE cycle.
    start_op(100, 3);
    @(negedge clk);
    start = 1'b1; dividend = 50; divisor = 5;
    wait_done(c);
    chk("midrun_lat", c, 8);
    chk("midrun_q", {24'd0, quotient}, 33);
    chk("midrun_r", {24'd0, remainder}, 1);
    do_op(50, 5);
    idle_gap();

    // Asynchronous reset 4 cycles into an op; start during reset is ignored.
    start_op(200, 7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_done", {31'd0, done}, 0);
    chk("arst_q", {24'd0, quotient}, 0);
    chk("arst_r", {24'd0, remainder}, 0);
    chk("arst_dbz", {31'd0, div_by_zero}, 0);
    start = 1'b1; dividend = 200; divisor = 7;
    @(posedge clk);
    #1;
    chk("rst_start_busy", {31'd0, busy}, 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("no_done_after_rst", {30'd0, done, busy}, 0);
    end
    do_op(9, 2);
    idle_gap();

    // Random pairs, mixing idle gaps and back-to-back issue.
    for (int i = 0; i < 2000; i++) begin
      rn = 8'($urandom_range(0, 255));
      rd = ($urandom_range(0, 19) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      do_op(rn, rd);
      if ($urandom_range(0, 1) == 1) idle_gap();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
